// File: rtl/yasac_uart_pkg.sv
// rtl/yasac_uart_pkg.sv - shared types and bit indices for the YASAC port UART transmitter
// Contents: FSM state enum, STATUS bit positions, TX_CTRL bit positions.
// Optional macro UART_PARITY_EN adds the PARITY state to the enum.
package yasac_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_e;

    // STATUS byte layout
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_ACK       = 3;
    localparam int ST_LEVEL_LSB = 4;
    localparam int ST_OVF       = 7;

    // TX_CTRL byte layout
    localparam int CTRL_SEND    = 0;
    localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART transmit state machine
// Ports: clk, resetn (sync, active low), push/wr_data, pop/rd_data (head, valid when !empty),
//        level (0..DEPTH), full, empty. Caller never pops when empty or pushes when full
//        without a same-cycle pop.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic [3:0] level,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 4'd1;
            end else if (pop && !push) begin
                level <= level - 4'd1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == 4'(DEPTH));
    assign empty   = (level == 4'd0);

endmodule

// File: rtl/port_uart_tx.sv
// rtl/port_uart_tx.sv - port-mapped UART transmitter (FIFO + 8N1 serialiser) for YASAC
// Ports: CLK, RESET_N (sync, active low), TX_DATA (byte from PORT00),
//        TX_CTRL (bit0 send toggle, bit1 clear overflow, from PORT01),
//        TXD (serial out, idle high), STATUS (busy/full/empty/ack/level/overflow, to PORT08).
// Optional macro UART_PARITY_EN inserts an even-parity bit between data and stop.
module port_uart_tx
    import yasac_uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] TX_DATA,
    input  logic [7:0] TX_CTRL,
    output logic       TXD,
    output logic [7:0] STATUS
);

    tx_state_e   state;
    logic        ctrl_q;
    logic        ack_q;
    logic        ovf_q;
    logic        txd_q;
    logic [15:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
`ifdef UART_PARITY_EN
    logic        parity_q;
`endif

    logic        send_req;
    logic        bit_end;
    logic        push;
    logic        pop;
    logic        drop;
    logic [7:0]  fifo_dout;
    logic [3:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;

    assign send_req = (TX_CTRL[CTRL_SEND] != ctrl_q);
    assign bit_end  = (div_cnt == 16'(CLK_DIV - 1));

    // Pop from IDLE, or at the end of STOP so the next frame starts with no idle gap.
    assign pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    // Fullness is judged after a same-cycle pop.
    assign push = send_req && (!fifo_full || pop);
    assign drop = send_req && fifo_full && !pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .resetn  (RESET_N),
        .push    (push),
        .wr_data (TX_DATA),
        .pop     (pop),
        .rd_data (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            // Both track the live toggle level so releasing reset never looks like a send.
            ctrl_q  <= TX_CTRL[CTRL_SEND];
            ack_q   <= TX_CTRL[CTRL_SEND];
            ovf_q   <= 1'b0;
            state   <= S_IDLE;
            txd_q   <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            ctrl_q <= TX_CTRL[CTRL_SEND];
            if (send_req) begin
                ack_q <= TX_CTRL[CTRL_SEND];
            end
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (TX_CTRL[CTRL_CLR_OVF]) begin
                ovf_q <= 1'b0;
            end

            if (pop) begin
                shift_q <= fifo_dout;
`ifdef UART_PARITY_EN
                parity_q <= ^fifo_dout;
`endif
            end

            if (state == S_IDLE) begin
                div_cnt <= '0;
                if (pop) begin
                    state <= S_START;
                    txd_q <= 1'b0;
                end
            end else if (!bit_end) begin
                div_cnt <= div_cnt + 16'd1;
            end else begin
                div_cnt <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        txd_q   <= shift_q[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= S_PARITY;
                            txd_q <= parity_q;
`else
                            state <= S_STOP;
                            txd_q <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        state <= S_STOP;
                        txd_q <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        if (pop) begin
                            state <= S_START;
                            txd_q <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        txd_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign TXD = txd_q;

    always_comb begin
        STATUS                       = '0;
        STATUS[ST_BUSY]              = (state != S_IDLE);
        STATUS[ST_FULL]              = fifo_full;
        STATUS[ST_EMPTY]             = fifo_empty;
        STATUS[ST_ACK]               = ack_q;
        // Three-bit field; level==8 (DEPTH 8, full) reads as 0 with full set.
        STATUS[ST_LEVEL_LSB +: 3]    = fifo_level[2:0];
        STATUS[ST_OVF]               = ovf_q;
    end

    logic unused_bits;
    assign unused_bits = ^{TX_CTRL[7:2], fifo_level[3]};

endmodule
